// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single write port of the 4-entry register
// file between requester 0 (ALU write-back) and requester 1 (load/immediate).
// Each requester has a one-entry buffer; at most one buffered write commits per
// cycle. Arbitration looks only at buffer state, never at incoming valids.
// Build option: define ARB_ROUND_ROBIN_EN for a 1-bit round-robin pointer on
// ties; otherwise requester 0 always wins ties (requester 1 may starve).

package regfile_pkg;
   typedef enum logic [1:0] {
      REG_R0 = 2'd0,
      REG_R1 = 2'd1,
      REG_R2 = 2'd2,
      REG_R3 = 2'd3
   } register_sel_e;

   typedef enum logic {
      REG_READ  = 1'b0,
      REG_WRITE = 1'b1
   } registers_op_e;
endpackage

module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  register_sel_e             req0_sel,
   input  logic [DATA_BUS_WIDTH-1:0] req0_data,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  register_sel_e             req1_sel,
   input  logic [DATA_BUS_WIDTH-1:0] req1_data,
   output registers_op_e             reg_op,
   output register_sel_e             reg_in_sel,
   output logic [DATA_BUS_WIDTH-1:0] reg_data_in,
   output logic [3:0]                busy,
   output logic [1:0]                grant
);

   logic                      full0_q, full0_d;
   register_sel_e             sel0_q, sel0_d;
   logic [DATA_BUS_WIDTH-1:0] data0_q, data0_d;
   logic                      full1_q, full1_d;
   register_sel_e             sel1_q, sel1_d;
   logic [DATA_BUS_WIDTH-1:0] data1_q, data1_d;

`ifdef ARB_ROUND_ROBIN_EN
   // 0: requester 0 wins the next tie, 1: requester 1 wins it
   logic ptr_q, ptr_d;
`endif

   logic prio0;
   logic win0, win1;
   logic acc0, acc1;

   // Arbitration, commit drive, handshake and next buffer state
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      prio0 = !ptr_q;
`else
      prio0 = 1'b1;
`endif
      win0 = full0_q && (!full1_q || prio0);
      win1 = full1_q && !win0;
      grant = {win1, win0};

      // A buffer draining this cycle can be refilled at the same edge
      req0_ready = !reset && (!full0_q || win0);
      req1_ready = !reset && (!full1_q || win1);

      reg_op      = REG_READ;
      reg_in_sel  = REG_R0;
      reg_data_in = '0;
      if (win0) begin
         reg_op      = REG_WRITE;
         reg_in_sel  = sel0_q;
         reg_data_in = data0_q;
      end else if (win1) begin
         reg_op      = REG_WRITE;
         reg_in_sel  = sel1_q;
         reg_data_in = data1_q;
      end

      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;

      full0_d = acc0 || (full0_q && !win0);
      sel0_d  = acc0 ? req0_sel  : sel0_q;
      data0_d = acc0 ? req0_data : data0_q;
      full1_d = acc1 || (full1_q && !win1);
      sel1_d  = acc1 ? req1_sel  : sel1_q;
      data1_d = acc1 ? req1_data : data1_q;

`ifdef ARB_ROUND_ROBIN_EN
      // After a commit, favour whichever requester did not win
      ptr_d = ptr_q;
      if (win0) begin
         ptr_d = 1'b1;
      end else if (win1) begin
         ptr_d = 1'b0;
      end
`endif
   end

   // Per-register pending-write flags straight from buffer contents
   always_comb begin
      busy = 4'b0000;
      if (full0_q) busy = busy | (4'b0001 << sel0_q);
      if (full1_q) busy = busy | (4'b0001 << sel1_q);
   end

   // Buffer registers; reset discards anything accepted but not committed
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full0_q <= 1'b0;
         sel0_q  <= REG_R0;
         data0_q <= '0;
         full1_q <= 1'b0;
         sel1_q  <= REG_R0;
         data1_q <= '0;
      end else begin
         full0_q <= full0_d;
         sel0_q  <= sel0_d;
         data0_q <= data0_d;
         full1_q <= full1_d;
         sel1_q  <= sel1_d;
         data1_q <= data1_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Tie-break pointer, favouring requester 0 out of reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

endmodule
